// File: rtl/store_buffer_p.sv
// store_buffer_p: speculative store buffer with commit/rollback, split cached/uncached drain and load-overlap check
module store_buffer_p #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 7,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req,
    input  logic [ID_W-1:0]  id,
    input  logic             cache,
    input  logic [31:0]      addr,
    input  logic [1:0]       size,
    input  logic [31:0]      data,
    input  logic             com,
    input  logic             rb,
    output logic             busy,
    output logic             dc_w,
    output logic [31:0]      dc_addr,
    output logic [1:0]       dc_size,
    output logic [31:0]      dc_data,
    input  logic             dc_ready,
    output logic             uc_w,
    output logic [31:0]      uc_addr,
    output logic [1:0]       uc_size,
    output logic [31:0]      uc_data,
    input  logic             uc_ready,
    input  logic [31:0]      q_addr,
    output logic             q_hit,
    output logic [CNT_W-1:0] rely,
    output logic [CNT_W-1:0] cur
);
    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [ID_W-1:0]  id_q    [DEPTH];
    logic             cache_q [DEPTH];
    logic [31:0]      addr_q  [DEPTH];
    logic [1:0]       size_q  [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [AW-1:0]    hd, off;
    logic             push, cm, pop, drain;

    // Pointers carry an extra MSB so full and empty stay distinguishable
    always_comb begin
        hd      = head_q[AW-1:0];
        rely    = tail_q - head_q;
        cur     = cmt_q - head_q;
        busy    = rely == CNT_W'(DEPTH);
        drain   = cur != '0;
        dc_w    = drain && cache_q[hd];
        uc_w    = drain && !cache_q[hd];
        dc_addr = addr_q[hd];
        dc_size = size_q[hd];
        dc_data = data_q[hd];
        uc_addr = addr_q[hd];
        uc_size = size_q[hd];
        uc_data = data_q[hd];
        pop     = (dc_w && dc_ready) || (uc_w && uc_ready);
        push    = req && !busy && !rb && size != 2'd0;
        cm      = com && !rb && cmt_q != tail_q;
        head_d  = head_q + CNT_W'(pop);
        cmt_d   = cmt_q + CNT_W'(cm);
        tail_d  = rb ? cmt_q : tail_q + CNT_W'(push);
        q_hit   = 1'b0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - hd;
            if ({1'b0, off} < rely && addr_q[i][31:2] == q_addr[31:2])
                q_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    // Payload storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            id_q[tail_q[AW-1:0]]    <= id;
            cache_q[tail_q[AW-1:0]] <= cache;
            addr_q[tail_q[AW-1:0]]  <= addr;
            size_q[tail_q[AW-1:0]]  <= size;
            data_q[tail_q[AW-1:0]]  <= data;
        end
    end
endmodule

// File: tb/tb_store_buffer_p.sv
// tb_store_buffer_p: directed vector table plus hand sequences for commit, rollback, wrap, overlap and async reset
module tb_store_buffer_p;
    logic        clk = 0, resetn = 0;
    logic        req = 0, cache = 0, com = 0, rb = 0, dc_ready = 0, uc_ready = 0;
    logic [6:0]  id = 0;
    logic [31:0] addr = 0, data = 0, q_addr = 0;
    logic [1:0]  size = 0;
    logic        busy, dc_w, uc_w, q_hit;
    logic [31:0] dc_addr, dc_data, uc_addr, uc_data;
    logic [1:0]  dc_size, uc_size;
    logic [3:0]  rely, cur;
    int checks = 0, failures = 0;

    store_buffer_p dut (
        .clk(clk), .resetn(resetn), .req(req), .id(id), .cache(cache), .addr(addr),
        .size(size), .data(data), .com(com), .rb(rb), .busy(busy),
        .dc_w(dc_w), .dc_addr(dc_addr), .dc_size(dc_size), .dc_data(dc_data), .dc_ready(dc_ready),
        .uc_w(uc_w), .uc_addr(uc_addr), .uc_size(uc_size), .uc_data(uc_data), .uc_ready(uc_ready),
        .q_addr(q_addr), .q_hit(q_hit), .rely(rely), .cur(cur)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, cache, com, rb, dcr;
        logic [31:0] addr, qa;
        logic [1:0]  size;
        logic [3:0]  rely, cur;
        logic        busy, dcw, ucw, qhit;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 0; cache = 0; com = 0; rb = 0; dc_ready = 0; uc_ready = 0;
        addr = 0; size = 0; data = 0; id = 0;
    endtask

    task automatic push(input logic c, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        req = 1; cache = c; addr = a; size = s; data = d; id = id + 1;
        tick();
        req = 0;
    endtask

    function automatic vec_t v(input logic rq, input logic c, input logic [31:0] a, input logic cm,
                               input logic r, input logic dr, input logic [31:0] qa,
                               input logic [3:0] el, input logic [3:0] ec, input logic eb,
                               input logic edw, input logic euw, input logic eq);
        vec_t t;
        t.req = rq; t.cache = c; t.addr = a; t.size = 2'd3; t.com = cm; t.rb = r; t.dcr = dr; t.qa = qa;
        t.rely = el; t.cur = ec; t.busy = eb; t.dcw = edw; t.ucw = euw; t.qhit = eq;
        return t;
    endfunction

    int n;

    initial begin
        for (int i = 0; i < 8; i++)
            vt[i] = v(1, 1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 4'(i + 1), 0, i == 7, 0, 0, 0);
        vt[8]  = v(1, 1, 32'h2000, 0, 0, 0, 0,          8, 0, 1, 0, 0, 0);
        vt[9]  = v(0, 0, 0,        0, 0, 0, 32'h1008,   8, 0, 1, 0, 0, 1);
        vt[10] = v(0, 0, 0,        0, 0, 0, 32'h2000,   8, 0, 1, 0, 0, 0);
        vt[11] = v(0, 0, 0,        1, 0, 0, 0,          8, 1, 1, 1, 0, 0);
        vt[12] = v(1, 1, 32'h3000, 0, 0, 1, 32'h3000,   7, 0, 0, 0, 0, 0);
        vt[13] = v(0, 0, 0,        0, 1, 0, 32'h1010,   0, 0, 0, 0, 0, 0);
        vt[14] = v(1, 1, 32'h4000, 0, 0, 0, 32'h4000,   0, 0, 0, 0, 0, 0);
        vt[15] = v(0, 0, 0,        1, 0, 0, 0,          0, 0, 0, 0, 0, 0);
        vt[14].size = 2'd0;

        #12;
        chk("rst_busy", busy, 0); chk("rst_dc_w", dc_w, 0); chk("rst_uc_w", uc_w, 0);
        chk("rst_q_hit", q_hit, 0); chk("rst_rely", rely, 0); chk("rst_cur", cur, 0);
        resetn = 1;
        tick();

        for (int i = 0; i < 16; i++) begin
            req = vt[i].req; cache = vt[i].cache; addr = vt[i].addr; size = vt[i].size;
            data = 32'(i); com = vt[i].com; rb = vt[i].rb; dc_ready = vt[i].dcr; q_addr = vt[i].qa;
            tick();
            chk($sformatf("vec%0d_rely", i), rely, vt[i].rely);
            chk($sformatf("vec%0d_cur", i), cur, vt[i].cur);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("vec%0d_dc_w", i), dc_w, vt[i].dcw);
            chk($sformatf("vec%0d_uc_w", i), uc_w, vt[i].ucw);
            chk($sformatf("vec%0d_q_hit", i), q_hit, vt[i].qhit);
        end
        idle(); q_addr = 0;

        push(1, 32'h100, 2'd3, 32'hAABBCCDD);
        com = 1; tick(); com = 0;
        for (int k = 0; k < 4; k++) begin
            chk("cd_dc_w", dc_w, 1); chk("cd_uc_w", uc_w, 0);
            chk("cd_addr", dc_addr, 32'h100); chk("cd_data", dc_data, 32'hAABBCCDD);
            chk("cd_size", dc_size, 3);
            if (k < 3) tick();
        end
        dc_ready = 1; tick(); dc_ready = 0;
        chk("cd_rely", rely, 0); chk("cd_dc_w_after", dc_w, 0);

        for (int k = 0; k < 4; k++) push(1, 32'h300 + 32'(4 * k), 2'd3, 32'(k));
        com = 1; tick(); tick(); com = 0;
        chk("rb_pre_cur", cur, 2); chk("rb_pre_rely", rely, 4);
        rb = 1; req = 1; cache = 1; addr = 32'h3F0; size = 2'd3; tick(); idle();
        chk("rb_rely", rely, 2); chk("rb_cur", cur, 2);
        q_addr = 32'h308; #1; chk("rb_qhit_rolled", q_hit, 0);
        q_addr = 32'h3F0; #1; chk("rb_qhit_dropped", q_hit, 0);
        q_addr = 0;
        chk("rb_head0", dc_addr, 32'h300);
        dc_ready = 1; tick();
        chk("rb_head1", dc_addr, 32'h304); chk("rb_rely1", rely, 1);
        tick(); dc_ready = 0;
        chk("rb_rely0", rely, 0); chk("rb_dc_w0", dc_w, 0);

        n = 0;
        for (int c = 0; c < 40 && n < 12; c++) begin
            req = c < 12; cache = (c % 2) == 0; addr = 32'h400 + 32'(4 * c); size = 2'd3;
            data = 32'(c); com = 1; dc_ready = 1; uc_ready = 1;
            #1;
            if (dc_w && uc_w) chk("wrap_both_valid", 1, 0);
            if (dc_w || uc_w) begin
                chk($sformatf("wrap%0d_route", n), dc_w, (n % 2) == 0);
                chk($sformatf("wrap%0d_addr", n), dc_w ? dc_addr : uc_addr, 32'h400 + 32'(4 * n));
                n++;
            end
            tick();
        end
        idle();
        chk("wrap_count", n, 12); chk("wrap_rely", rely, 0);

        push(0, 32'h203, 2'd1, 32'h5A);
        q_addr = 32'h200; #1; chk("fw_hit", q_hit, 1);
        q_addr = 32'h204; #1; chk("fw_miss", q_hit, 0);
        com = 1; tick(); com = 0;
        chk("fw_uc_w", uc_w, 1); chk("fw_dc_w", dc_w, 0); chk("fw_uc_addr", uc_addr, 32'h203);
        chk("fw_uc_size", uc_size, 1); chk("fw_uc_data", uc_data, 32'h5A);
        uc_ready = 1; tick(); uc_ready = 0;
        q_addr = 32'h200; #1; chk("fw_drained", q_hit, 0); chk("fw_rely", rely, 0);

        push(0, 32'h500, 2'd3, 32'h77);
        com = 1; tick(); com = 0;
        q_addr = 32'h500; #1;
        chk("ar_uc_w_pre", uc_w, 1); chk("ar_qhit_pre", q_hit, 1);
        #2; resetn = 0; #1;
        chk("ar_uc_w", uc_w, 0); chk("ar_rely", rely, 0); chk("ar_busy", busy, 0);
        chk("ar_cur", cur, 0); chk("ar_dc_w", dc_w, 0); chk("ar_qhit", q_hit, 0);
        tick(); resetn = 1; tick();
        chk("ar_rely_post", rely, 0); chk("ar_uc_w_post", uc_w, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
